// File: rtl/chain_code_encoder_if.sv
// Pixel-read bus and chain-code stream between the encoder and its
// pixel memory and code sink.
interface chain_code_encoder_if #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
);
  logic                       pix_rd;
  logic [$clog2(IMG_H)-1:0]   pix_row;
  logic [$clog2(IMG_W)-1:0]   pix_col;
  logic                       pix_data;
  logic [2:0]                 code;
  logic                       code_valid;
  logic                       code_ready;

  modport master (
    output pix_rd, pix_row, pix_col, code, code_valid,
    input  pix_data, code_ready
  );

  modport slave (
    input  pix_rd, pix_row, pix_col, code, code_valid,
    output pix_data, code_ready
  );
endinterface

// File: rtl/chain_code_encoder.sv
// Freeman chain-code contour encoder: raster-scans for the first object pixel,
// traces its boundary into a code buffer, then streams the codes out.
// Macro CHAIN_CODE_AREA_EN adds an AREA pass counting object pixels; when it
// is undefined TRACE goes straight to SEND and area is tied to 0.
module chain_code_encoder #(
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter int unsigned MAX_CODES = 1024,
  localparam int unsigned CW = $clog2(IMG_W),
  localparam int unsigned RW = $clog2(IMG_H),
  localparam int unsigned PW = $clog2(MAX_CODES + 1),
  localparam int unsigned AW = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  chain_code_encoder_if.master bus,
  output logic [PW-1:0]        perimeter,
  output logic [AW-1:0]        area,
  output logic [RW-1:0]        start_row,
  output logic [CW-1:0]        start_col,
  output logic                 done,
  output logic                 error
);
  localparam int unsigned BW = (MAX_CODES > 1) ? $clog2(MAX_CODES) : 1;

  typedef enum logic [2:0] {StIdle, StScan, StTrace, StArea, StSend, StDone} state_e;

`ifdef CHAIN_CODE_AREA_EN
  localparam state_e TraceClosedSt = StArea;
  localparam state_e TraceIsoSt    = StArea;
`else
  localparam state_e TraceClosedSt = StSend;
  localparam state_e TraceIsoSt    = StDone;
`endif

  state_e state_q, state_d;

  logic          ph_q, ph_d;  // 0: issue read, 1: evaluate pix_data
  logic [RW-1:0] scan_row_q, scan_row_d, cur_row_q, cur_row_d, start_row_q, start_row_d;
  logic [CW-1:0] scan_col_q, scan_col_d, cur_col_q, cur_col_d, start_col_q, start_col_d;
  logic [2:0]    prev_dir_q, prev_dir_d, probe_q, probe_d;
  logic [PW-1:0] perim_q, perim_d, rd_ptr_q, rd_ptr_d;
  logic          done_q, done_d, error_q, error_d;
`ifdef CHAIN_CODE_AREA_EN
  logic [AW-1:0] area_q, area_d;
`endif

  logic [2:0]    code_mem [MAX_CODES];

  logic [2:0]    probe_dir;
  logic          step_n, step_s, step_e, step_w, nb_in, nb_is_start;
  logic [RW-1:0] nb_row, scan_row_nx;
  logic [CW-1:0] nb_col, scan_col_nx;
  logic          scan_last, hit, miss, buf_full, buf_we, send_active, xfer, start_req;

  // Neighbour under probe, image-boundary clipping and handshake qualifiers
  always_comb begin
    probe_dir   = prev_dir_q + 3'd6 + probe_q;
    step_n      = probe_dir inside {3'd1, 3'd2, 3'd3};
    step_s      = probe_dir inside {3'd5, 3'd6, 3'd7};
    step_e      = probe_dir inside {3'd7, 3'd0, 3'd1};
    step_w      = probe_dir inside {3'd3, 3'd4, 3'd5};
    nb_in       = !(step_n && cur_row_q == '0) && !(step_s && cur_row_q == RW'(IMG_H - 1)) &&
                  !(step_w && cur_col_q == '0) && !(step_e && cur_col_q == CW'(IMG_W - 1));
    nb_row      = step_n ? cur_row_q - RW'(1) : (step_s ? cur_row_q + RW'(1) : cur_row_q);
    nb_col      = step_w ? cur_col_q - CW'(1) : (step_e ? cur_col_q + CW'(1) : cur_col_q);
    nb_is_start = (nb_row == start_row_q) && (nb_col == start_col_q);
    scan_last   = (scan_row_q == RW'(IMG_H - 1)) && (scan_col_q == CW'(IMG_W - 1));
    scan_col_nx = (scan_col_q == CW'(IMG_W - 1)) ? '0 : scan_col_q + CW'(1);
    scan_row_nx = (scan_col_q == CW'(IMG_W - 1)) ? scan_row_q + RW'(1) : scan_row_q;
    hit         = (state_q == StTrace) && ph_q && bus.pix_data;
    miss        = (state_q == StTrace) && (ph_q ? !bus.pix_data : !nb_in);
    buf_full    = (perim_q == PW'(MAX_CODES));
    buf_we      = hit && !buf_full;
    send_active = (state_q == StSend) && (rd_ptr_q != perim_q);
    xfer        = send_active && bus.code_ready;
    start_req   = start && ((state_q == StIdle) || (state_q == StDone));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StScan;
      StScan: begin
        if (ph_q) begin
          if (bus.pix_data)   state_d = StTrace;
          else if (scan_last) state_d = StDone;
        end
      end
      StTrace: begin
        if (hit) begin
          if (buf_full)         state_d = StDone;
          else if (nb_is_start) state_d = TraceClosedSt;
        end else if (miss && probe_q == 3'd7) begin
          state_d = TraceIsoSt;
        end
      end
`ifdef CHAIN_CODE_AREA_EN
      StArea: if (ph_q && scan_last) state_d = (perim_q == '0) ? StDone : StSend;
`endif
      StSend: if (xfer && (rd_ptr_q + PW'(1) == perim_q)) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: pixel bus and code stream
  always_comb begin
    bus.pix_rd     = 1'b0;
    bus.pix_row    = '0;
    bus.pix_col    = '0;
    bus.code       = 3'd0;
    bus.code_valid = 1'b0;
    unique case (state_q)
      StScan, StArea: begin
        bus.pix_rd  = !ph_q;
        bus.pix_row = scan_row_q;
        bus.pix_col = scan_col_q;
      end
      StTrace: begin
        bus.pix_rd  = !ph_q && nb_in;
        bus.pix_row = nb_row;
        bus.pix_col = nb_col;
      end
      StSend: begin
        bus.code_valid = send_active;
        if (send_active) bus.code = code_mem[rd_ptr_q[BW-1:0]];
      end
      default: ;
    endcase
  end

  // Datapath next-state: scan/trace position, counters and status flags
  always_comb begin
    ph_d        = ph_q;
    scan_row_d  = scan_row_q;
    scan_col_d  = scan_col_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    start_row_d = start_row_q;
    start_col_d = start_col_q;
    prev_dir_d  = prev_dir_q;
    probe_d     = probe_q;
    perim_d     = perim_q;
    rd_ptr_d    = rd_ptr_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef CHAIN_CODE_AREA_EN
    area_d      = area_q;
    if (start_req) area_d = '0;
`endif
    if (start_req) begin
      ph_d        = 1'b0;
      scan_row_d  = '0;
      scan_col_d  = '0;
      start_row_d = '0;
      start_col_d = '0;
      perim_d     = '0;
      rd_ptr_d    = '0;
      done_d      = 1'b0;
      error_d     = 1'b0;
    end
    case (state_q)
      StScan: begin
        ph_d = !ph_q;
        if (ph_q) begin
          if (bus.pix_data) begin
            start_row_d = scan_row_q;
            start_col_d = scan_col_q;
            cur_row_d   = scan_row_q;
            cur_col_d   = scan_col_q;
            prev_dir_d  = 3'd0;
            probe_d     = 3'd0;
            scan_row_d  = '0;  // rewound for the area pass
            scan_col_d  = '0;
          end else if (scan_last) begin
            error_d = 1'b1;
          end else begin
            scan_row_d = scan_row_nx;
            scan_col_d = scan_col_nx;
          end
        end
      end
      StTrace: begin
        if (hit) begin
          ph_d = 1'b0;
          if (buf_full) begin
            error_d = 1'b1;
          end else begin
            perim_d    = perim_q + PW'(1);
            prev_dir_d = probe_dir;
            cur_row_d  = nb_row;
            cur_col_d  = nb_col;
            probe_d    = 3'd0;
          end
        end else if (miss) begin
          ph_d    = 1'b0;
          probe_d = probe_q + 3'd1;
        end else begin
          ph_d = 1'b1;
        end
      end
`ifdef CHAIN_CODE_AREA_EN
      StArea: begin
        ph_d = !ph_q;
        if (ph_q) begin
          if (bus.pix_data) area_d = area_q + AW'(1);
          scan_row_d = scan_row_nx;
          scan_col_d = scan_col_nx;
        end
      end
`endif
      StSend: if (xfer) rd_ptr_d = rd_ptr_q + PW'(1);
      default: ;
    endcase
    if (state_d == StDone && state_q != StDone) done_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q        <= 1'b0;
      scan_row_q  <= '0;
      scan_col_q  <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      start_row_q <= '0;
      start_col_q <= '0;
      prev_dir_q  <= 3'd0;
      probe_q     <= 3'd0;
      perim_q     <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef CHAIN_CODE_AREA_EN
      area_q      <= '0;
`endif
    end else begin
      ph_q        <= ph_d;
      scan_row_q  <= scan_row_d;
      scan_col_q  <= scan_col_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      start_row_q <= start_row_d;
      start_col_q <= start_col_d;
      prev_dir_q  <= prev_dir_d;
      probe_q     <= probe_d;
      perim_q     <= perim_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef CHAIN_CODE_AREA_EN
      area_q      <= area_d;
`endif
    end
  end

  // Code buffer; contents are dead once the pointers are reset
  always_ff @(posedge clk) begin
    if (buf_we) code_mem[perim_q[BW-1:0]] <= probe_dir;
  end

  assign perimeter = perim_q;
  assign start_row = start_row_q;
  assign start_col = start_col_q;
  assign done      = done_q;
  assign error     = error_q;
`ifdef CHAIN_CODE_AREA_EN
  assign area      = area_q;
`else
  assign area      = '0;
`endif
endmodule

// File: tb/tb_chain_code_encoder.sv
// Scoreboard bench for chain_code_encoder: directed images, expected codes
// queued at stimulus time and popped by an independent stream monitor.
module tb_chain_code_encoder;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int MC = 16;
`ifdef CHAIN_CODE_AREA_EN
  localparam bit AreaOn = 1'b1;
`else
  localparam bit AreaOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  perimeter;
  logic [12:0] area;
  logic [5:0]  start_row;
  logic [5:0]  start_col;
  logic        done;
  logic        error;

  chain_code_encoder_if #(.IMG_W(W), .IMG_H(H)) bus ();

  chain_code_encoder #(.IMG_W(W), .IMG_H(H), .MAX_CODES(MC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .perimeter(perimeter),
    .area     (area),
    .start_row(start_row),
    .start_col(start_col),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  logic       img [H][W];
  int         rd_count = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         ready_toggle = 1'b0;
  logic [2:0] exp_q [$];

  // Pixel memory: data one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.pix_rd) rd_count <= rd_count + 1;
    bus.pix_data <= bus.pix_rd ? img[bus.pix_row][bus.pix_col] : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Sink ready: always high, or toggling every 3 cycles
  initial begin : ready_drv
    int k;
    k = 0;
    bus.code_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      bus.code_ready = ready_toggle ? ((k / 3) % 2 == 0) : 1'b1;
    end
  end

  // Stream monitor: pops expected codes on each transfer, checks hold while stalled
  initial begin : monitor
    logic       pv;
    logic       pr;
    logic [2:0] pc;
    pv = 1'b0;
    pr = 1'b0;
    pc = 3'd0;
    forever begin
      @(negedge clk);
      if (reset_n && pv && !pr) begin
        chk("code_valid_held", bus.code_valid, 1);
        chk("code_value_held", bus.code, pc);
      end
      if (bus.code_valid && bus.code_ready) begin
        if (exp_q.size() == 0) chk("spurious_code_valid", bus.code_valid, 0);
        else                   chk("code", bus.code, exp_q.pop_front());
      end
      pv = bus.code_valid && reset_n;
      pr = bus.code_ready;
      pc = bus.code;
    end
  end

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic fill(input int r0, input int c0, input int r1, input int c1);
    for (int y = r0; y <= r1; y++)
      for (int x = c0; x <= c1; x++) img[y][x] = 1'b1;
  endtask

  // One encode: pulse start, wait for done, check status; reads < 0 skips read count
  task automatic run(input string nm, input int er, input int ec, input int ep, input int ea,
                     input int eerr, input int reads, input bit area_pass);
    int base;
    int n;
    base = rd_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_error"}, error, eerr);
    chk({nm, "_start_row"}, start_row, er);
    chk({nm, "_start_col"}, start_col, ec);
    chk({nm, "_perimeter"}, perimeter, ep);
    chk({nm, "_area"}, area, AreaOn ? ea : 0);
    if (reads >= 0)
      chk({nm, "_pix_reads"}, rd_count - base, reads + ((AreaOn && area_pass) ? W * H : 0));
    repeat (4) @(negedge clk);
    chk({nm, "_codes_left"}, exp_q.size(), 0);
    chk({nm, "_done_holds"}, done, 1);
    chk({nm, "_perimeter_holds"}, perimeter, ep);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_code"}, bus.code, 0);
    chk({nm, "_code_valid"}, bus.code_valid, 0);
    chk({nm, "_pix_rd"}, bus.pix_rd, 0);
    chk({nm, "_pix_row"}, bus.pix_row, 0);
    chk({nm, "_pix_col"}, bus.pix_col, 0);
    chk({nm, "_perimeter"}, perimeter, 0);
    chk({nm, "_area"}, area, 0);
    chk({nm, "_start_row"}, start_row, 0);
    chk({nm, "_start_col"}, start_col, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
  endtask

  initial begin : main
    int base;
    int n;
    clear_img();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Isolated pixel
    clear_img();
    img[5][7] = 1'b1;
    run("single", 5, 7, 0, 1, 0, 336, 1'b1);

    // 2x2 block, ready always high
    clear_img();
    fill(10, 10, 11, 11);
    exp_q.push_back(3'd6); exp_q.push_back(3'd0);
    exp_q.push_back(3'd2); exp_q.push_back(3'd4);
    run("block", 10, 10, 4, 4, 0, 667, 1'b1);

    // Same block with a stalling sink
    ready_toggle = 1'b1;
    exp_q.push_back(3'd6); exp_q.push_back(3'd0);
    exp_q.push_back(3'd2); exp_q.push_back(3'd4);
    run("block_stall", 10, 10, 4, 4, 0, 667, 1'b1);
    ready_toggle = 1'b0;

    // Empty image
    clear_img();
    run("empty", 0, 0, 0, 0, 1, W * H, 1'b0);

    // Block in the corner: edge probes must not read
    clear_img();
    fill(0, 0, 1, 1);
    exp_q.push_back(3'd6); exp_q.push_back(3'd0);
    exp_q.push_back(3'd2); exp_q.push_back(3'd4);
    run("corner", 0, 0, 4, 4, 0, 12, 1'b1);

    // Horizontal 3-pixel line
    clear_img();
    fill(20, 30, 20, 32);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd4); exp_q.push_back(3'd4);
    run("line", 20, 30, 4, 3, 0, 1327, 1'b1);

    // 6x6 square needs 20 codes, buffer holds 16
    clear_img();
    fill(30, 40, 35, 45);
    run("overflow", 30, 40, 16, 0, 1, -1, 1'b0);

    // Reset mid-trace, then a clean encode
    clear_img();
    fill(10, 10, 11, 11);
    base = rd_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rd_count - base < 653 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midtrace_reached", (rd_count - base >= 653), 1);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle_pix_rd", bus.pix_rd, 0);
    chk("post_reset_idle_done", done, 0);
    exp_q.push_back(3'd6); exp_q.push_back(3'd0);
    exp_q.push_back(3'd2); exp_q.push_back(3'd4);
    run("after_reset", 10, 10, 4, 4, 0, 667, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/chain_code_encoder.md
CHAIN_CODE_ENCODER -- requirements
Module: chain_code_encoder

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels; minimum 2.
REQ-002 Parameter IMG_H, default 64: image height in pixels; minimum 2.
REQ-003 Parameter MAX_CODES, default 1024: depth of the code buffer, in 3-bit entries.
REQ-004 Derived widths SHALL be:
- CW = $clog2(IMG_W)
- RW = $clog2(IMG_H)
- PW = $clog2(MAX_CODES+1)
- AW = $clog2(IMG_W*IMG_H+1)
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  level request to begin encoding; sampled in IDLE and DONE.
REQ-008 pix_rd  out  1  pixel read strobe.
REQ-009 pix_row  out  RW  pixel read row.
REQ-010 pix_col  out  CW  pixel read column.
REQ-011 pix_data  in  1  pixel value (1 = object), valid exactly one cycle after pix_rd.
REQ-012 code  out  3  Freeman direction code.
REQ-013 code_valid  out  1  code is valid.
REQ-014 code_ready  in  1  sink accepts code; a transfer occurs when code_valid and code_ready are both high.
REQ-015 perimeter  out  PW  number of chain codes.
REQ-016 area  out  AW  count of object pixels.
REQ-017 start_row  out  RW  first object pixel row; start_col  out  CW  first object pixel column.
REQ-018 done  out  1  encoding finished; error  out  1  encoding failed.

Function
REQ-019 The FSM SHALL have the states IDLE, SCAN, TRACE, AREA, SEND and DONE.
REQ-020 IDLE with start=1 SHALL clear the counters, error and the code buffer, then enter SCAN.
REQ-021 SCAN SHALL read pixels in raster order (row-major, from (0,0)); the first pixel read as 1 SHALL latch start_row/start_col and enter TRACE.
REQ-022 If SCAN finds no object pixel, the block SHALL set error=1 and done=1 and enter DONE.
REQ-023 Direction codes SHALL be: 0=E, 1=NE, 2=N, 3=NW, 4=W, 5=SW, 6=S, 7=SE; N means row-1.
REQ-024 TRACE SHALL start with prev_dir=0; at each pixel it SHALL probe neighbours in order (prev_dir+6) mod 8, incrementing mod 8, for at most 8 probes.
REQ-025 The first probed neighbour equal to 1 SHALL be the move: push its code to the buffer, perimeter+1, prev_dir=code, current pixel=that neighbour.
REQ-026 Out-of-image neighbours SHALL read as 0, SHALL NOT assert pix_rd, and SHALL take one cycle each.
REQ-027 Each in-image probe SHALL take two cycles: read, then evaluate.
REQ-028 TRACE SHALL terminate when a move lands on the start pixel, after that final code has been pushed.
REQ-029 If all 8 probes of a pixel return 0 (isolated pixel), TRACE SHALL end with perimeter=0.
REQ-030 A push while the buffer holds MAX_CODES entries SHALL set error=1 and done=1 and enter DONE, with no further codes sent.
REQ-031 AREA SHALL scan all IMG_W*IMG_H pixels and count the 1s into area, then enter SEND.
REQ-032 SEND SHALL present the buffered codes in push order.
REQ-033 While code_valid=1 and code_ready=0, code SHALL hold stable; code_valid SHALL NOT drop before its transfer.
REQ-034 When the buffer empties, or immediately if perimeter=0, the block SHALL set done=1 and enter DONE.
REQ-035 perimeter, area, start_row and start_col SHALL hold their values in DONE.
REQ-036 DONE with start=1 SHALL behave as IDLE with start=1.
REQ-037 Counters SHALL NOT wrap: perimeter is bounded by the overflow rule (REQ-030), and area is sized for the full image.

Reset
REQ-038 reset_n=0 SHALL immediately force IDLE and drive to 0: code, code_valid, pix_rd, pix_row, pix_col, perimeter, area, start_row, start_col, done and error.
REQ-039 Assertion of reset in any state, including mid-TRACE or mid-SEND, SHALL discard the buffer contents; no code SHALL appear after reset is released until a new start.

Configuration
REQ-040 Macro CHAIN_CODE_AREA_EN defined: the AREA state and area counter SHALL be present, as in REQ-031.
REQ-041 Macro CHAIN_CODE_AREA_EN undefined: TRACE SHALL go directly to SEND, and area SHALL be constant 0.

Verification
REQ-042 Single pixel at (5,7), 64x64 -> start_row=5, start_col=7, perimeter=0, area=1, no code transfers, done=1, error=0.
REQ-043 2x2 block at rows 10-11, cols 10-11, code_ready=1 -> codes 6,0,2,4 in order, perimeter=4, area=4, done=1.
REQ-044 Same 2x2 block, code_ready toggling every 3 cycles -> identical code sequence, each code held stable while unaccepted.
REQ-045 All-zero image -> error=1 and done=1 after 4096 pixel reads, perimeter=0.
REQ-046 Object touching (0,0) -> no pix_rd issued outside the image, and a correct closed chain.
REQ-047 Two checks:
- reset_n pulsed low mid-TRACE, then start -> outputs at 0 during reset, followed by a clean full encode.
- Build without CHAIN_CODE_AREA_EN -> area=0 and a shorter time to done.
